// File: rtl/fir_coef_bank_ctrl.sv
// Double-buffered FIR tap RAM: session writes land in the shadow bank and swap atomically on frame sync.
// Build with FIR_COEF_ZERO_FILL_EN to zero unwritten shadow taps before the swap (full-set loads).
module fir_coef_bank_ctrl #(
  parameter real TCQ       = 0.1,
  parameter int  TAP_NUM   = 32,
  parameter int  TAP_WIDTH = 16,
  parameter int  AW        = $clog2(TAP_NUM)
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_i,
  input  logic                 fir_tap_wr_cmd_i,
  input  logic [31:0]          fir_tap_wr_addr_i,
  input  logic                 fir_tap_wr_vld_i,
  input  logic [31:0]          fir_tap_wr_data_i,
  input  logic                 fir_frame_sync_i,
  input  logic [AW-1:0]        coef_rd_addr_i,
  output logic [TAP_WIDTH-1:0] coef_rd_data_o,
  output logic                 coef_bank_sel_o,
  output logic                 load_busy_o,
  output logic                 load_done_o,
  output logic [2:0]           load_err_o,
  output logic [AW:0]          tap_cnt_o
);

  typedef enum logic [2:0] {IDLE, LOAD, ZFILL, WAIT_SYNC, COPY} state_t;

  state_t               state, state_nxt;
  logic                 cmd_d;
  logic                 rise, fall;
  logic                 accept;
  logic                 idx_last;
  logic                 shadow_sel;
  logic [AW:0]          wr_ptr;
  logic [AW-1:0]        idx;
  logic [TAP_WIDTH-1:0] bank [2][TAP_NUM];

  assign rise       = fir_tap_wr_cmd_i & ~cmd_d;
  assign fall       = ~fir_tap_wr_cmd_i & cmd_d;
  assign shadow_sel = ~coef_bank_sel_o;
  assign idx_last   = (idx == AW'(TAP_NUM - 1));
  // wr_ptr[AW] set means the pointer ran past the last tap; it never wraps
  assign accept     = (state == LOAD) && fir_tap_wr_vld_i && !wr_ptr[AW] && !load_err_o[0];

  generate
    if (TAP_WIDTH < 32) begin : g_unused
      logic unused_data;
      assign unused_data = ^fir_tap_wr_data_i[31:TAP_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cmd_d <= 1'b0;
    end else begin
      state <= state_nxt;
      cmd_d <= fir_tap_wr_cmd_i;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (rise) state_nxt = LOAD;
      LOAD: begin
        if (fall) begin
          // a strobe coinciding with the fall still counts towards the session
          if (tap_cnt_o == '0 && !accept) state_nxt = IDLE;
`ifdef FIR_COEF_ZERO_FILL_EN
          else state_nxt = ZFILL;
`else
          else state_nxt = WAIT_SYNC;
`endif
        end
      end
      ZFILL:     if (idx_last) state_nxt = WAIT_SYNC;
      WAIT_SYNC: if (fir_frame_sync_i) state_nxt = COPY;
      COPY:      if (idx_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_busy_o = 1'b0;
    if (state != IDLE && state != LOAD) load_busy_o = 1'b1;
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr          <= '0;
      tap_cnt_o       <= '0;
      load_err_o      <= '0;
      load_done_o     <= 1'b0;
      coef_bank_sel_o <= 1'b0;
      idx             <= '0;
    end else begin
      load_done_o <= 1'b0;
      idx         <= (state == ZFILL || state == COPY) ? idx + AW'(1) : '0;
      if (state == IDLE && rise) begin
        wr_ptr     <= {1'b0, fir_tap_wr_addr_i[AW-1:0]};
        tap_cnt_o  <= '0;
        load_err_o <= {2'b00, (fir_tap_wr_addr_i >= 32'(TAP_NUM))};
      end else begin
        // a session opened while busy is dropped wholesale; only flag it
        if (rise && load_busy_o) load_err_o[2] <= 1'b1;
        if (accept) begin
          wr_ptr    <= wr_ptr + (AW+1)'(1);
          tap_cnt_o <= tap_cnt_o + (AW+1)'(1);
        end else if (state == LOAD && fir_tap_wr_vld_i) begin
          load_err_o[1] <= 1'b1;
        end
      end
      if (state == WAIT_SYNC && fir_frame_sync_i) begin
        coef_bank_sel_o <= ~coef_bank_sel_o;
        load_done_o     <= 1'b1;
      end
    end
  end

`ifdef FIR_COEF_ZERO_FILL_EN
  logic [TAP_NUM-1:0] mask;

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      mask <= '0;
    end else if (state == IDLE && rise) begin
      mask <= '0;
    end else if (accept) begin
      mask[wr_ptr[AW-1:0]] <= 1'b1;
    end
  end
`endif

  // tap RAM is intentionally not reset so a reset keeps the loaded coefficients
  always_ff @(posedge clk_sys_i) begin
    if (accept)
      bank[shadow_sel][wr_ptr[AW-1:0]] <= fir_tap_wr_data_i[TAP_WIDTH-1:0];
`ifdef FIR_COEF_ZERO_FILL_EN
    else if (state == ZFILL && !mask[idx])
      bank[shadow_sel][idx] <= '0;
`endif
    else if (state == COPY)
      bank[shadow_sel][idx] <= bank[coef_bank_sel_o][idx];
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) coef_rd_data_o <= '0;
    else       coef_rd_data_o <= bank[coef_bank_sel_o][coef_rd_addr_i];
  end

endmodule

// File: tb/tb_fir_coef_bank_ctrl.sv
// Directed bench for fir_coef_bank_ctrl: session table plus busy-reject and reset-in-COPY sequences.
module tb_fir_coef_bank_ctrl;
  localparam int TAP_NUM = 32;
  localparam int TW      = 16;
  localparam int AW      = 5;
`ifdef FIR_COEF_ZERO_FILL_EN
  localparam bit ZF     = 1'b1;
  localparam int ZF_CYC = TAP_NUM;
`else
  localparam bit ZF     = 1'b0;
  localparam int ZF_CYC = 0;
`endif

  logic          clk;
  logic          rst;
  logic          cmd;
  logic [31:0]   wr_addr;
  logic          vld;
  logic [31:0]   wr_data;
  logic          sync;
  logic [AW-1:0] rd_addr;
  logic [TW-1:0] rd_data;
  logic          bank_sel;
  logic          busy;
  logic          done;
  logic [2:0]    err;
  logic [AW:0]   tap_cnt;

  int tests;
  int failed;
  logic [TW-1:0] model [TAP_NUM];

  typedef struct {
    logic [31:0] addr;
    int          n;
    logic [15:0] d0;
    logic [15:0] step;
    logic [2:0]  exp_err;
    int          exp_cnt;
    bit          exp_swap;
    bit          exp_sel;
  } sess_t;
  sess_t tbl[4];

  fir_coef_bank_ctrl dut (
    .clk_sys_i         (clk),
    .rst_i             (rst),
    .fir_tap_wr_cmd_i  (cmd),
    .fir_tap_wr_addr_i (wr_addr),
    .fir_tap_wr_vld_i  (vld),
    .fir_tap_wr_data_i (wr_data),
    .fir_frame_sync_i  (sync),
    .coef_rd_addr_i    (rd_addr),
    .coef_rd_data_o    (rd_data),
    .coef_bank_sel_o   (bank_sel),
    .load_busy_o       (busy),
    .load_done_o       (done),
    .load_err_o        (err),
    .tap_cnt_o         (tap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected active set after a swap, derived from session semantics alone
  task automatic model_update(input logic [31:0] addr, input int n, input logic [15:0] d0,
                              input logic [15:0] step);
    if (ZF) for (int i = 0; i < TAP_NUM; i++) model[i] = '0;
    if (addr < TAP_NUM) begin
      for (int k = 0; k < n; k++) begin
        if (addr + k < TAP_NUM) model[addr + k] = 16'(d0 + k * step);
      end
    end
  endtask

  task automatic run_session(input logic [31:0] addr, input int n, input logic [15:0] d0,
                             input logic [15:0] step);
    cmd = 1'b1;
    wr_addr = addr;
    tick();
    for (int k = 0; k < n; k++) begin
      vld = 1'b1;
      wr_data = {16'hC0DE, 16'(d0 + k * step)};
      tick();
    end
    vld = 1'b0;
    wr_data = '0;
    cmd = 1'b0;
    tick();
  endtask

  task automatic do_sync(input string tag, input bit exp_sel);
    repeat (ZF_CYC + 10) tick();
    chk({tag, " done before sync"}, done, 0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk({tag, " done"}, done, 1);
    chk({tag, " bank_sel"}, bank_sel, exp_sel);
    tick();
    chk({tag, " done pulse width"}, done, 0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 200) begin
      tick();
      k++;
    end
    chk({tag, " busy drop"}, busy, 0);
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < TAP_NUM; i++) begin
      rd_addr = AW'(i);
      tick();
      chk($sformatf("%s tap%0d", tag, i), rd_data, model[i]);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    cmd = 1'b0;
    wr_addr = '0;
    vld = 1'b0;
    wr_data = '0;
    sync = 1'b0;
    rd_addr = '0;
    for (int i = 0; i < TAP_NUM; i++) model[i] = '0;

    //        addr   n   d0        step     err     cnt swap sel
    tbl[0] = '{32'd0,  32, 16'h0001, 16'h0001, 3'b000, 32, 1'b1, 1'b1};
    tbl[1] = '{32'd4,  2,  16'hAAAA, 16'h1111, 3'b000, 2,  1'b1, 1'b0};
    tbl[2] = '{32'd30, 4,  16'h3000, 16'h0001, 3'b010, 2,  1'b1, 1'b1};
    tbl[3] = '{32'd40, 0,  16'h0000, 16'h0000, 3'b001, 0,  1'b0, 1'b1};

    repeat (3) tick();
    chk("rst rd_data", rd_data, 0);
    chk("rst bank_sel", bank_sel, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst tap_cnt", tap_cnt, 0);
    rst = 1'b0;
    tick();

    for (int s = 0; s < 4; s++) begin
      string tag;
      tag = $sformatf("s%0d", s);
      run_session(tbl[s].addr, tbl[s].n, tbl[s].d0, tbl[s].step);
      chk({tag, " busy after fall"}, busy, tbl[s].exp_swap);
      if (tbl[s].exp_swap) begin
        do_sync(tag, tbl[s].exp_sel);
        wait_idle(tag);
        model_update(tbl[s].addr, tbl[s].n, tbl[s].d0, tbl[s].step);
      end else begin
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk({tag, " stray sync done"}, done, 0);
        chk({tag, " stray sync bank_sel"}, bank_sel, tbl[s].exp_sel);
      end
      chk({tag, " err"}, err, tbl[s].exp_err);
      chk({tag, " tap_cnt"}, tap_cnt, tbl[s].exp_cnt);
      readback(tag);
    end

    // second session opened while waiting for sync must be dropped entirely
    run_session(32'd8, 1, 16'h1234, 16'h0000);
    repeat (ZF_CYC + 2) tick();
    chk("rej in wait_sync", busy, 1);
    run_session(32'd9, 2, 16'hDEAD, 16'h0001);
    chk("rej err", err, 3'b100);
    chk("rej still busy", busy, 1);
    do_sync("rej", 1'b0);
    wait_idle("rej");
    model_update(32'd8, 1, 16'h1234, 16'h0000);
    chk("rej tap_cnt", tap_cnt, 1);
    readback("rej");

    // reset a few cycles into the copy-back
    run_session(32'd0, 1, 16'h5555, 16'h0000);
    do_sync("rcopy", 1'b1);
    repeat (3) tick();
    chk("rcopy busy before rst", busy, 1);
    rst = 1'b1;
    #1;
    chk("rcopy rd_data", rd_data, 0);
    chk("rcopy bank_sel", bank_sel, 0);
    chk("rcopy busy", busy, 0);
    chk("rcopy done", done, 0);
    chk("rcopy err", err, 0);
    chk("rcopy tap_cnt", tap_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    run_session(32'd0, 32, 16'h0100, 16'h0001);
    chk("post busy after fall", busy, 1);
    do_sync("post", 1'b1);
    wait_idle("post");
    model_update(32'd0, 32, 16'h0100, 16'h0001);
    chk("post err", err, 0);
    chk("post tap_cnt", tap_cnt, 32);
    readback("post");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
